uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the SoC's single-byte UART transmit path.
- Accepts bytes on a tx_send/tx_data strobe interface and buffers them in an internal FIFO.
- Serialises them LSB-first onto uart_tx, with configurable data width, parity mode, stop bits and bit period.
- Sits between the SoC's MMIO UART register and the uart_tx pin. Exposes ready, busy, fill-level and sticky overflow status for software and bench monitors.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit. Values below 1 are treated as 1; 1 is the simulation setting.
- DATA_BITS, 8, payload bits per frame. Legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.
- FIFO_DEPTH, 4, FIFO entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset: synchronous, active-low.
- tx_send  input  1  write strobe; one byte accepted per cycle it is high and tx_ready=1.
- tx_data  input  8  byte to send; only bits [DATA_BITS-1:0] are transmitted.
- tx_ready  output  1  high when the FIFO is not full.
- uart_tx  output  1  serial line; idles high; registered output.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a write is dropped; cleared only by reset.

Behaviour:
- Reset: while rstn=0 at a rising edge, all of the following are forced. uart_tx=1, busy=0, fifo_count=0, overflow=0, tx_ready=1. FSM goes to IDLE, FIFO pointers go to 0, the bit counter and baud counter are cleared. Reset mid-frame aborts the frame; uart_tx is 1 after that edge; no partial frame resumes.
- FIFO write: occurs when tx_send=1 and count<FIFO_DEPTH. tx_ready is computed from the registered count. A write while full is dropped and sets overflow, even if a pop happens on the same edge. A simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, the next edge pops the head into the shift register, enters START and drives uart_tx=0.
  - START: holds for CLKS_PER_BIT cycles, then enters DATA.
  - DATA: transmits DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. Afterwards enters PARITY if PARITY!=0, otherwise STOP.
  - PARITY: holds one bit period. Odd mode: the bit makes the total count of ones in data plus parity odd. Even mode: the bit makes that total even.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle, if the FIFO is non-empty, it pops directly into START with no idle gap; otherwise it returns to IDLE.
- Latency: for a write at edge N into an empty FIFO with the FSM in IDLE, uart_tx falls at edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, exactly.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1 every edge advances one bit.
- Pointers: use $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- busy: equals (state!=IDLE) || (fifo_count!=0), registered.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, 8N1, write 0x55 at edge 10. uart_tx=0 during cycles 11-14, then bits 1,0,1,0,1,0,1,0 each for 4 cycles, then high. busy falls at edge 51.
- Parity: PARITY=2, write 0xA5 -> parity bit 0. PARITY=1, write 0xA5 -> parity bit 1. PARITY=1, write 0x01 -> parity bit 0. Frame length is 44 cycles at CLKS_PER_BIT=4.
- Overflow: FIFO_DEPTH=4, 8N1, CLKS_PER_BIT=4, five consecutive writes 0x41..0x45 starting with the FSM idle.
  - First byte popped at the 2nd edge, so all five are accepted; overflow=0.
  - A sixth write immediately after is dropped and sets overflow=1; tx_ready=0 on that cycle.
  - Five frames are sent back to back in exactly 200 cycles, with no idle gap.
- Simultaneous push/pop: with the FIFO full, assert tx_send on the same edge as a STOP->START pop. The write is dropped, overflow=1, fifo_count goes 4->3.
- Reset mid-frame: deassert rstn for one edge during DATA bit 3. Next cycle: uart_tx=1, fifo_count=0, busy=0, overflow=0. A new write of 0x0F then produces a clean frame.
- Fast/min config: CLKS_PER_BIT=1, DATA_BITS=5, STOP_BITS=2, write 0x1F. Frame is 0,1,1,1,1,1,1,1 = 8 cycles; bits 7:5 of tx_data are ignored.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal byte FIFO: bytes written on tx_send are queued
// and serialised LSB-first with configurable width, parity, stop bits and bit period.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          tx_send,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int Cpb   = (CLKS_PER_BIT < 1) ? 1 : CLKS_PER_BIT;
  localparam int BaudW = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int PtrW  = $clog2(FIFO_DEPTH);
  localparam int CntW  = PtrW + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(Cpb - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [2:0]       DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // FIFO storage and control
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  // Serialiser
  logic [2:0]           state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d, baud_inc;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_last;
  logic                 unused_tx_data;

  // Bits above DATA_BITS are never transmitted.
  assign unused_tx_data = ^tx_data;

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign push      = tx_send && !full;
  assign head      = mem[rd_ptr_q];
  assign baud_last = (baud_q == BaudLast);
  assign baud_inc  = baud_last ? '0 : baud_q + 1'b1;

  assign tx_ready   = !full;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A write into a full FIFO is lost even when a pop frees a slot on the same edge.
    ovf_d = ovf_q | (tx_send & full);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 1);
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        baud_d = baud_inc;
        if (baud_last) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_inc;
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        baud_d = baud_inc;
        if (baud_last) begin
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        baud_d = baud_inc;
        if (baud_last) begin
          if (bit_q != StopLast) begin
            bit_d = bit_q + 3'd1;
          end else if (!empty) begin
            // Back-to-back frame: go straight to the next start bit.
            pop     = 1'b1;
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 1);
            baud_d  = '0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data[DATA_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations, a cycle-exact serial-line scoreboard
// fed at write time, plus hand-written overflow, push/pop collision and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rstn_v;
  logic [3:0]  send_v;
  logic [7:0]  data_v [4];
  wire  [3:0]  ready_v;
  wire  [3:0]  uart_v;
  wire  [3:0]  busy_v;
  wire  [3:0]  ovf_v;
  wire  [11:0] cnt_all;
  wire  [2:0]  cnt_a = cnt_all[2:0];

  // 0: 8N1 x4, 1: 8E1 x4, 2: 8O1 x4, 3: 5N2 x1
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_a (.clk(clk), .rstn(rstn_v[0]), .tx_send(send_v[0]), .tx_data(data_v[0]),
         .tx_ready(ready_v[0]), .uart_tx(uart_v[0]), .busy(busy_v[0]),
         .fifo_count(cnt_all[2:0]), .overflow(ovf_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_e (.clk(clk), .rstn(rstn_v[1]), .tx_send(send_v[1]), .tx_data(data_v[1]),
         .tx_ready(ready_v[1]), .uart_tx(uart_v[1]), .busy(busy_v[1]),
         .fifo_count(cnt_all[5:3]), .overflow(ovf_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_o (.clk(clk), .rstn(rstn_v[2]), .tx_send(send_v[2]), .tx_data(data_v[2]),
         .tx_ready(ready_v[2]), .uart_tx(uart_v[2]), .busy(busy_v[2]),
         .fifo_count(cnt_all[8:6]), .overflow(ovf_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_f (.clk(clk), .rstn(rstn_v[3]), .tx_send(send_v[3]), .tx_data(data_v[3]),
         .tx_ready(ready_v[3]), .uart_tx(uart_v[3]), .busy(busy_v[3]),
         .fifo_count(cnt_all[11:9]), .overflow(ovf_v[3]));

  int cfg_cpb [4] = '{4, 4, 4, 1};
  int cfg_nb  [4] = '{8, 8, 8, 5};
  int cfg_sb  [4] = '{1, 1, 1, 2};

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         par;   // expected parity bit, -1 when the frame has none
    int         len;   // expected frame length in cycles
  } vec_t;
  vec_t vecs [8];

  int   checks   = 0;
  int   failures = 0;
  logic exp_q [$];
  logic mon_on   = 1'b0;
  logic mon_done = 1'b0;
  logic mon_bit;
  int   mon_idx  = 0;
  int   mon_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int idx, input logic [7:0] b, input int par);
    int         cpb;
    logic [7:0] bv;
    int         pv;
    cpb = cfg_cpb[idx];
    bv  = b;
    pv  = par;
    repeat (cpb) exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_nb[idx]; i++) repeat (cpb) exp_q.push_back(bv[i]);
    if (pv >= 0) repeat (cpb) exp_q.push_back(pv[0]);
    repeat (cfg_sb[idx] * cpb) exp_q.push_back(1'b1);
  endtask

  task automatic write1(input int idx, input logic [7:0] b);
    send_v[idx] = 1'b1;
    data_v[idx] = b;
    tick();
    send_v[idx] = 1'b0;
  endtask

  task automatic start_mon(input int idx);
    mon_idx  = idx;
    mon_cnt  = 0;
    mon_done = 1'b0;
    mon_on   = 1'b1;
  endtask

  task automatic wait_mon(input int budget);
    for (int i = 0; i < budget && !mon_done; i++) tick();
    chk("monitor_done", {31'd0, mon_done}, 32'd1);
    if (!mon_done) begin
      mon_on = 1'b0;
      exp_q.delete();
    end
  endtask

  // Scoreboard: one expected line value per cycle, starting on the write edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() != 0) begin
        mon_bit = exp_q.pop_front();
        chk("uart_tx", {31'd0, uart_v[mon_idx]}, {31'd0, mon_bit});
        chk("busy_in_frame", {31'd0, busy_v[mon_idx]}, 32'd1);
        mon_cnt++;
      end else begin
        chk("uart_tx_idle", {31'd0, uart_v[mon_idx]}, 32'd1);
        chk("busy_end", {31'd0, busy_v[mon_idx]}, 32'd0);
        mon_on   = 1'b0;
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_v = '0;
    send_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    vecs[0] = '{0, 8'h55, -1, 40};
    vecs[1] = '{1, 8'hA5,  0, 44};
    vecs[2] = '{2, 8'hA5,  1, 44};
    vecs[3] = '{2, 8'h01,  0, 44};
    vecs[4] = '{2, 8'hFF,  1, 44};
    vecs[5] = '{1, 8'h07,  1, 44};
    vecs[6] = '{3, 8'h1F, -1, 8};
    vecs[7] = '{3, 8'hEA, -1, 8};

    tick();
    tick();
    chk("rst_uart_tx", {31'd0, uart_v[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_count", {29'd0, cnt_a}, 32'd0);
    chk("rst_overflow", {31'd0, ovf_v[0]}, 32'd0);
    chk("rst_ready", {31'd0, ready_v[0]}, 32'd1);
    chk("rst_uart_all", {28'd0, uart_v}, 32'hF);
    rstn_v = '1;
    tick();

    // Single frames per configuration.
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(1'b1);
      push_frame(vecs[v].idx, vecs[v].data, vecs[v].par);
      write1(vecs[v].idx, vecs[v].data);
      start_mon(vecs[v].idx);
      wait_mon(vecs[v].len + 10);
      chk($sformatf("vec%0d_len", v), mon_cnt - 1, vecs[v].len);
      tick();
    end

    // Five writes fill the FIFO (one popped on the 2nd edge); the sixth is dropped.
    exp_q.push_back(1'b1);
    for (int b = 8'h41; b <= 8'h45; b++) push_frame(0, 8'(b), -1);
    send_v[0] = 1'b1;
    data_v[0] = 8'h41;
    tick();
    start_mon(0);
    for (int b = 8'h42; b <= 8'h45; b++) begin
      data_v[0] = 8'(b);
      tick();
    end
    chk("ovf_after_five", {31'd0, ovf_v[0]}, 32'd0);
    chk("ready_when_full", {31'd0, ready_v[0]}, 32'd0);
    chk("count_full", {29'd0, cnt_a}, 32'd4);
    data_v[0] = 8'h46;
    tick();
    send_v[0] = 1'b0;
    chk("ovf_after_sixth", {31'd0, ovf_v[0]}, 32'd1);
    chk("count_after_drop", {29'd0, cnt_a}, 32'd4);
    wait_mon(260);
    chk("stream_len", mon_cnt - 1, 200);
    tick();

    // Full FIFO, write lands on the same edge as the STOP->START pop.
    rstn_v[0] = 1'b0;
    tick();
    rstn_v[0] = 1'b1;
    chk("ovf_cleared", {31'd0, ovf_v[0]}, 32'd0);
    exp_q.push_back(1'b1);
    for (int b = 8'h61; b <= 8'h65; b++) push_frame(0, 8'(b), -1);
    send_v[0] = 1'b1;
    data_v[0] = 8'h61;
    tick();
    start_mon(0);
    for (int b = 8'h62; b <= 8'h65; b++) begin
      data_v[0] = 8'(b);
      tick();
    end
    send_v[0] = 1'b0;
    repeat (36) tick();
    chk("count_before_pop", {29'd0, cnt_a}, 32'd4);
    chk("ready_before_pop", {31'd0, ready_v[0]}, 32'd0);
    chk("ovf_before_pop", {31'd0, ovf_v[0]}, 32'd0);
    send_v[0] = 1'b1;
    data_v[0] = 8'h99;
    tick();
    send_v[0] = 1'b0;
    chk("count_after_pop", {29'd0, cnt_a}, 32'd3);
    chk("ovf_on_pop_edge", {31'd0, ovf_v[0]}, 32'd1);
    chk("ready_after_pop", {31'd0, ready_v[0]}, 32'd1);
    wait_mon(260);
    chk("stream2_len", mon_cnt - 1, 200);
    tick();

    // Reset during data bit 3 of 0x33 (bit 3 is 0).
    write1(0, 8'h33);
    repeat (17) tick();
    chk("mid_frame_bit3", {31'd0, uart_v[0]}, 32'd0);
    chk("mid_frame_busy", {31'd0, busy_v[0]}, 32'd1);
    rstn_v[0] = 1'b0;
    tick();
    rstn_v[0] = 1'b1;
    chk("abort_uart_tx", {31'd0, uart_v[0]}, 32'd1);
    chk("abort_count", {29'd0, cnt_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("abort_overflow", {31'd0, ovf_v[0]}, 32'd0);
    tick();
    chk("abort_no_resume", {31'd0, uart_v[0]}, 32'd1);
    exp_q.push_back(1'b1);
    push_frame(0, 8'h0F, -1);
    write1(0, 8'h0F);
    start_mon(0);
    wait_mon(60);
    chk("clean_frame_len", mon_cnt - 1, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
